// File: rtl/amba_axi4_stream_fifo_pkg.sv
// ---------------------------------------------------------------------------
// amba_axi4_stream_fifo_pkg
// Shared constants and helpers for the AXI4-Stream FIFO slice.
//   MIN_DEPTH : smallest legal DEPTH (beats)
//   w_msb()   : sideband width -> MSB index; a width of 0 maps to a 1-bit
//               field (MSB 0)
// The beat storage layout, MSB to LSB, is {last, user, dest, id, keep, strb,
// data}. It depends on module parameters, so the packed struct itself is
// declared in the top level using w_msb() for the sideband fields.
// ---------------------------------------------------------------------------
package amba_axi4_stream_fifo_pkg;

  localparam int unsigned MIN_DEPTH = 2;

  function automatic int unsigned w_msb(input int unsigned width);
    return (width == 0) ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/amba_axi4_stream_fifo_if.sv
// ---------------------------------------------------------------------------
// amba_axi4_stream_fifo_if
// One AXI4-Stream link (handshake + payload).
//   master : drives TVALID and payload, receives TREADY
//   slave  : receives TVALID and payload, drives TREADY
// Sidebands with a width parameter of 0 collapse to an unused 1-bit field.
// ---------------------------------------------------------------------------
interface amba_axi4_stream_fifo_if
  import amba_axi4_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_BYTES = 4,
  parameter int unsigned ID_WIDTH         = 0,
  parameter int unsigned DEST_WIDTH       = 0,
  parameter int unsigned USER_WIDTH       = 0
);

  logic                            TVALID;
  logic                            TREADY;
  logic [8*DATA_WIDTH_BYTES-1:0]   TDATA;
  logic [DATA_WIDTH_BYTES-1:0]     TSTRB;
  logic [DATA_WIDTH_BYTES-1:0]     TKEEP;
  logic                            TLAST;
  logic [w_msb(ID_WIDTH):0]        TID;
  logic [w_msb(DEST_WIDTH):0]      TDEST;
  logic [w_msb(USER_WIDTH):0]      TUSER;

  modport master (
    output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
    output TREADY
  );

endinterface

// File: rtl/amba_axi4_stream_fifo_mem.sv
// ---------------------------------------------------------------------------
// amba_axi4_stream_fifo_mem
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   i_clk   : clock (rising edge)
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ---------------------------------------------------------------------------
module amba_axi4_stream_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/amba_axi4_stream_fifo.sv
// ---------------------------------------------------------------------------
// amba_axi4_stream_fifo
// AXI4-Stream synchronous FIFO, DEPTH beats of {TDATA,TSTRB,TKEEP,TLAST,TID,
// TDEST,TUSER}. Registered TREADY, no bypass path (one cycle fall-through).
//   ACLK    : clock (rising edge)
//   ARESETn : asynchronous active-low reset
//   s_axis  : input stream (slave modport)
//   m_axis  : output stream (master modport)
//   LEVEL   : beats currently stored (registered)
// Optional macro AXI4_STREAM_FIFO_PACKET_MODE_EN: store-and-forward; output
// TVALID is held off until a complete packet is stored, or the FIFO is full.
// ---------------------------------------------------------------------------
module amba_axi4_stream_fifo
  import amba_axi4_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_BYTES = 4,
  parameter int unsigned ID_WIDTH         = 0,
  parameter int unsigned DEST_WIDTH       = 0,
  parameter int unsigned USER_WIDTH       = 0,
  parameter int unsigned DEPTH            = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  amba_axi4_stream_fifo_if.slave    s_axis,
  amba_axi4_stream_fifo_if.master   m_axis,
  output logic [$clog2(DEPTH):0]    LEVEL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic                          last;
    logic [w_msb(USER_WIDTH):0]    user;
    logic [w_msb(DEST_WIDTH):0]    dest;
    logic [w_msb(ID_WIDTH):0]      id;
    logic [DATA_WIDTH_BYTES-1:0]   keep;
    logic [DATA_WIDTH_BYTES-1:0]   strb;
    logic [8*DATA_WIDTH_BYTES-1:0] data;
  } beat_t;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_s_tready;
  logic [AW:0]   w_count_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_m_tvalid;
  beat_t         w_wr_beat;
  beat_t         w_rd_beat;

  assign w_push = s_axis.TVALID & r_s_tready;
  assign w_pop  = w_m_tvalid & m_axis.TREADY;
  assign w_full = (r_count == CNT_FULL);

  // Zero-width sidebands are stored as constant 0 so the output reads 0.
  always_comb begin
    w_wr_beat      = '0;
    w_wr_beat.last = s_axis.TLAST;
    w_wr_beat.user = (USER_WIDTH == 0) ? '0 : s_axis.TUSER;
    w_wr_beat.dest = (DEST_WIDTH == 0) ? '0 : s_axis.TDEST;
    w_wr_beat.id   = (ID_WIDTH   == 0) ? '0 : s_axis.TID;
    w_wr_beat.keep = s_axis.TKEEP;
    w_wr_beat.strb = s_axis.TSTRB;
    w_wr_beat.data = s_axis.TDATA;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // TREADY is the registered !full of the next count, so a pop while full
  // re-opens the input one cycle later rather than in the same cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_s_tready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_s_tready <= (w_count_nxt != CNT_FULL);
    end
  end

`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
  logic [AW:0] r_pkt_cnt;
  logic        w_pkt_in;
  logic        w_pkt_out;

  assign w_pkt_in  = w_push & s_axis.TLAST;
  assign w_pkt_out = w_pop & w_rd_beat.last;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_in && !w_pkt_out) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
    end else if (!w_pkt_in && w_pkt_out) begin
      r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
    end
  end

  // Full override lets packets longer than DEPTH drain instead of deadlocking.
  // Both terms only fall on a pop, so TVALID never drops before a handshake.
  assign w_m_tvalid = (r_count != '0) & ((r_pkt_cnt != '0) | w_full);
`else
  assign w_m_tvalid = (r_count != '0);
`endif

  amba_axi4_stream_fifo_mem #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (ACLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  assign s_axis.TREADY = r_s_tready;

  assign m_axis.TVALID = w_m_tvalid;
  assign m_axis.TDATA  = w_rd_beat.data;
  assign m_axis.TSTRB  = w_rd_beat.strb;
  assign m_axis.TKEEP  = w_rd_beat.keep;
  assign m_axis.TLAST  = w_rd_beat.last;
  assign m_axis.TID    = w_rd_beat.id;
  assign m_axis.TDEST  = w_rd_beat.dest;
  assign m_axis.TUSER  = w_rd_beat.user;

  assign LEVEL = r_count;

endmodule

// File: tb/tb_amba_axi4_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_amba_axi4_stream_fifo
// Directed bench for amba_axi4_stream_fifo (DEPTH=16, 32-bit data, no
// sidebands). Expectations that differ between cut-through and packet mode
// are selected by AXI4_STREAM_FIFO_PACKET_MODE_EN.
// ---------------------------------------------------------------------------
module tb_amba_axi4_stream_fifo;

  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
  localparam logic PKT = 1'b1;
`else
  localparam logic PKT = 1'b0;
`endif

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [4:0] LEVEL;

  amba_axi4_stream_fifo_if #(.DATA_WIDTH_BYTES(DB)) s_if ();
  amba_axi4_stream_fifo_if #(.DATA_WIDTH_BYTES(DB)) m_if ();

  amba_axi4_stream_fifo #(
    .DATA_WIDTH_BYTES (DB),
    .ID_WIDTH         (0),
    .DEST_WIDTH       (0),
    .USER_WIDTH       (0),
    .DEPTH            (DEPTH)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .LEVEL   (LEVEL)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  logic [31:0] d;
  logic [3:0]  k;
  logic [36:0] q [$];   // {last, keep, data}
  logic        do_push;
  logic        do_pop;
  logic        saw_full_valid;
  int unsigned sent;
  int unsigned rcvd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at 1 time unit after a rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] data, input logic [3:0] keep, input logic last);
    s_if.TVALID = 1'b1;
    s_if.TDATA  = data;
    s_if.TSTRB  = keep;
    s_if.TKEEP  = keep;
    s_if.TLAST  = last;
    tick();
    s_if.TVALID = 1'b0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
  endtask

  initial begin
    ARESETn     = 1'b0;
    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    s_if.TSTRB  = '0;
    s_if.TKEEP  = '0;
    s_if.TLAST  = 1'b0;
    s_if.TID    = 1'b1;
    s_if.TDEST  = 1'b1;
    s_if.TUSER  = 1'b1;
    m_if.TREADY = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_m_tvalid", 64'(m_if.TVALID), 0);
    chk("rst_s_tready", 64'(s_if.TREADY), 0);
    chk("rst_level", 64'(LEVEL), 0);
    ARESETn = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(s_if.TREADY), 0);
    tick();
    chk("rdy_after_edge", 64'(s_if.TREADY), 1);

    // Single beat, one-cycle latency, no bypass
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'hA5A5_0001;
    s_if.TSTRB  = 4'h5;
    s_if.TKEEP  = 4'hF;
    s_if.TLAST  = 1'b1;
    #1;
    chk("t1_no_bypass", 64'(m_if.TVALID), 0);
    tick();
    s_if.TVALID = 1'b0;
    chk("t1_valid", 64'(m_if.TVALID), 1);
    chk("t1_data", 64'(m_if.TDATA), 64'h A5A5_0001);
    chk("t1_strb", 64'(m_if.TSTRB), 4'h5);
    chk("t1_keep", 64'(m_if.TKEEP), 4'hF);
    chk("t1_last", 64'(m_if.TLAST), 1);
    chk("t1_tid_zero", 64'(m_if.TID), 0);
    chk("t1_tdest_zero", 64'(m_if.TDEST), 0);
    chk("t1_tuser_zero", 64'(m_if.TUSER), 0);
    chk("t1_level1", 64'(LEVEL), 1);
    m_if.TREADY = 1'b1;
    tick();
    m_if.TREADY = 1'b0;
    chk("t1_valid_after_pop", 64'(m_if.TVALID), 0);
    chk("t1_level0", 64'(LEVEL), 0);

    // Fill to DEPTH with the sink stalled
    for (int i = 0; i < 16; i++) begin
      push(32'h0000_0100 + 32'(i), 4'hF, 1'b0);
    end
    chk("full_s_tready", 64'(s_if.TREADY), 0);
    chk("full_level", 64'(LEVEL), 16);
    chk("full_valid", 64'(m_if.TVALID), 1);
    chk("full_head", 64'(m_if.TDATA), 32'h100);
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'hDEAD_0200;
    m_if.TREADY = 1'b1;
    #1;
    chk("full_pop_rdy_same", 64'(s_if.TREADY), 0);
    tick();
    s_if.TVALID = 1'b0;
    m_if.TREADY = 1'b0;
    chk("full_pop_rdy_next", 64'(s_if.TREADY), 1);
    chk("full_pop_level", 64'(LEVEL), 15);
    chk("full_pop_head", 64'(m_if.TDATA), 32'h101);
    chk("full_pop_valid", 64'(m_if.TVALID), 64'(!PKT));
    do_reset();
    chk("fill_reset_level", 64'(LEVEL), 0);

    // Steady state at LEVEL=5 with simultaneous push/pop, across wrap-around
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      k = 4'($urandom_range(15, 0));
      push(d, k, 1'b1);
      q.push_back({1'b1, k, d});
    end
    chk("ss_level_init", 64'(LEVEL), 5);
    s_if.TVALID = 1'b1;
    s_if.TLAST  = 1'b1;
    m_if.TREADY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      k = 4'($urandom_range(15, 0));
      s_if.TDATA = d;
      s_if.TKEEP = k;
      s_if.TSTRB = k;
      #1;
      chk("ss_data", 64'(m_if.TDATA), 64'(q[0][31:0]));
      chk("ss_keep", 64'(m_if.TKEEP), 64'(q[0][35:32]));
      chk("ss_level", 64'(LEVEL), 5);
      tick();
      void'(q.pop_front());
      q.push_back({1'b1, k, d});
    end
    s_if.TVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ss_drain_data", 64'(m_if.TDATA), 64'(q[0][31:0]));
      tick();
      void'(q.pop_front());
    end
    m_if.TREADY = 1'b0;
    chk("ss_drain_level", 64'(LEVEL), 0);
    chk("ss_drain_valid", 64'(m_if.TVALID), 0);

    // Partial packet, then its last beat
    for (int i = 0; i < 3; i++) begin
      push(32'h0000_0400 + 32'(i), 4'hF, 1'b0);
    end
    chk("pk3_valid", 64'(m_if.TVALID), 64'(!PKT));
    chk("pk3_level", 64'(LEVEL), 3);
    push(32'h0000_0403, 4'hF, 1'b1);
    chk("pk4_valid", 64'(m_if.TVALID), 1);
    m_if.TREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pk4_data", 64'(m_if.TDATA), 64'(32'h400 + 32'(i)));
      chk("pk4_last", 64'(m_if.TLAST), 64'(i == 3));
      tick();
    end
    m_if.TREADY = 1'b0;
    chk("pk4_level", 64'(LEVEL), 0);

    // 20-beat packet through a 16-deep FIFO, sink always ready
    sent = 0;
    rcvd = 0;
    saw_full_valid = 1'b0;
    m_if.TREADY = 1'b1;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      s_if.TVALID = (sent < 20);
      s_if.TDATA  = 32'h0000_0500 + 32'(sent);
      s_if.TKEEP  = 4'hF;
      s_if.TSTRB  = 4'hF;
      s_if.TLAST  = (sent == 19);
      #1;
      if (LEVEL == 5'd16 && m_if.TVALID) saw_full_valid = 1'b1;
      do_push = s_if.TVALID & s_if.TREADY;
      do_pop  = m_if.TVALID & m_if.TREADY;
      if (do_pop) begin
        chk("p20_data", 64'(m_if.TDATA), 64'(32'h500 + 32'(rcvd)));
        chk("p20_last", 64'(m_if.TLAST), 64'(rcvd == 19));
        rcvd++;
      end
      tick();
      if (do_push) sent++;
    end
    s_if.TVALID = 1'b0;
    m_if.TREADY = 1'b0;
    chk("p20_rcvd", 64'(rcvd), 20);
    chk("p20_level", 64'(LEVEL), 0);
    chk("p20_full_override", 64'(saw_full_valid), 64'(PKT));

    // Reset mid-packet at LEVEL=7
    for (int i = 0; i < 7; i++) begin
      push(32'h0000_0600 + 32'(i), 4'hF, 1'b0);
    end
    chk("mid_level7", 64'(LEVEL), 7);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_if.TVALID), 0);
    chk("mid_rst_ready", 64'(s_if.TREADY), 0);
    chk("mid_rst_level", 64'(LEVEL), 0);
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    chk("post_rst_ready", 64'(s_if.TREADY), 1);
    chk("post_rst_valid", 64'(m_if.TVALID), 0);
    push(32'hBEEF_0001, 4'hF, 1'b1);
    chk("post_rst_new_valid", 64'(m_if.TVALID), 1);
    chk("post_rst_new_data", 64'(m_if.TDATA), 32'hBEEF_0001);
    chk("post_rst_new_level", 64'(LEVEL), 1);
    m_if.TREADY = 1'b1;
    tick();
    m_if.TREADY = 1'b0;
    chk("post_rst_empty_valid", 64'(m_if.TVALID), 0);
    chk("post_rst_empty_level", 64'(LEVEL), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
